// File: rtl/mult_product_combine.sv
// mult_product_combine: reassembles eight 18x18 signed partial products into packed
// 8/16/32-bit element products and returns the low or high half of each, two stages deep.
module mult_product_combine #(
  parameter int DATA_WIDTH = 64,
  parameter int PROD_WIDTH = 36,
  parameter int SEW_WIDTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [8*PROD_WIDTH-1:0] in_prod,
  input  logic [SEW_WIDTH-1:0]    in_sew,
  input  logic                    in_hi,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [SEW_WIDTH-1:0]    out_sew,
  output logic                    out_err
);

  localparam int NUM_PROD = 8;
  localparam int NUM_HALF = 4;
  localparam int NUM_WORD = 2;
  localparam int PER_WORD = 4;
  localparam int BYTE_W   = 8;
  localparam int HALF_W   = 16;
  localparam int WORD_W   = 32;

  localparam logic [SEW_WIDTH-1:0] SEW_E8  = 2'd0;
  localparam logic [SEW_WIDTH-1:0] SEW_E16 = 2'd1;
  localparam logic [SEW_WIDTH-1:0] SEW_E32 = 2'd2;

  function automatic logic [63:0] sext36(input logic [35:0] v);
    return {{28{v[35]}}, v};
  endfunction

  function automatic logic [63:0] sext37(input logic [36:0] v);
    return {{27{v[36]}}, v};
  endfunction

  logic [PROD_WIDTH-1:0]                prod_s [NUM_PROD];

  logic                                 v1_s;
  logic [SEW_WIDTH-1:0]                 sew1_s;
  logic                                 hi1_s;
  logic [NUM_WORD-1:0][PROD_WIDTH-1:0]  q0_s;
  logic [NUM_WORD-1:0][PROD_WIDTH-1:0]  q3_s;
  logic [NUM_WORD-1:0][PROD_WIDTH:0]    cross_s;
  logic [DATA_WIDTH-1:0]                lo_s;
  logic [DATA_WIDTH-1:0]                hi_s;

  logic                                 v1_r;
  logic [SEW_WIDTH-1:0]                 sew1_r;
  logic                                 hi1_r;
  logic [NUM_WORD-1:0][PROD_WIDTH-1:0]  q0_r;
  logic [NUM_WORD-1:0][PROD_WIDTH-1:0]  q3_r;
  logic [NUM_WORD-1:0][PROD_WIDTH:0]    cross_r;
  logic [DATA_WIDTH-1:0]                lo_r;
  logic [DATA_WIDTH-1:0]                hi_r;

  logic [NUM_WORD-1:0][63:0]            full_s;
  logic [DATA_WIDTH-1:0]                data2_s;
  logic [SEW_WIDTH-1:0]                 sew2_s;
  logic                                 err2_s;

  // Split the flat input bus into the eight signed partial products.
  always_comb begin
    for (int k = 0; k < NUM_PROD; k++) begin
      prod_s[k] = in_prod[PROD_WIDTH*k +: PROD_WIDTH];
    end
  end

  // Stage-1 next values: cross sums, corner products and the low/high slices; bubbles load zeros.
  always_comb begin
    v1_s    = 1'b0;
    sew1_s  = '0;
    hi1_s   = 1'b0;
    q0_s    = '0;
    q3_s    = '0;
    cross_s = '0;
    lo_s    = '0;
    hi_s    = '0;
    if (in_valid) begin
      v1_s   = 1'b1;
      sew1_s = in_sew;
      hi1_s  = in_hi;
      for (int e = 0; e < NUM_WORD; e++) begin
        q0_s[e]    = prod_s[PER_WORD*e];
        q3_s[e]    = prod_s[PER_WORD*e + 3];
        cross_s[e] = {prod_s[PER_WORD*e + 1][PROD_WIDTH-1], prod_s[PER_WORD*e + 1]}
                   + {prod_s[PER_WORD*e + 2][PROD_WIDTH-1], prod_s[PER_WORD*e + 2]};
      end
      case (in_sew)
        SEW_E8: begin
          for (int k = 0; k < NUM_PROD; k++) begin
            lo_s[BYTE_W*k +: BYTE_W] = prod_s[k][7:0];
            hi_s[BYTE_W*k +: BYTE_W] = prod_s[k][15:8];
          end
        end
        SEW_E16: begin
          for (int k = 0; k < NUM_HALF; k++) begin
            lo_s[HALF_W*k +: HALF_W] = prod_s[k][15:0];
            hi_s[HALF_W*k +: HALF_W] = prod_s[k][31:16];
          end
        end
        default: begin
          lo_s = '0;
          hi_s = '0;
        end
      endcase
    end else begin
      v1_s    = 1'b0;
      sew1_s  = '0;
      hi1_s   = 1'b0;
    end
  end

  // Stage-1 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      sew1_r  <= '0;
      hi1_r   <= 1'b0;
      q0_r    <= '0;
      q3_r    <= '0;
      cross_r <= '0;
      lo_r    <= '0;
      hi_r    <= '0;
    end else begin
      v1_r    <= v1_s;
      sew1_r  <= sew1_s;
      hi1_r   <= hi1_s;
      q0_r    <= q0_s;
      q3_r    <= q3_s;
      cross_r <= cross_s;
      lo_r    <= lo_s;
      hi_r    <= hi_s;
    end
  end

  // Stage-2 next values: 64-bit shift-add per 32-bit element, half selection and packing.
  always_comb begin
    for (int e = 0; e < NUM_WORD; e++) begin
      full_s[e] = sext36(q0_r[e])
                + (sext37(cross_r[e]) << 6'd16)
                + (sext36(q3_r[e]) << 6'd32);
    end
    data2_s = '0;
    sew2_s  = '0;
    err2_s  = 1'b0;
    if (v1_r) begin
      sew2_s = sew1_r;
      case (sew1_r)
        SEW_E8, SEW_E16: begin
          data2_s = hi1_r ? hi_r : lo_r;
        end
        SEW_E32: begin
          for (int e = 0; e < NUM_WORD; e++) begin
            data2_s[WORD_W*e +: WORD_W] = hi1_r ? full_s[e][63:32] : full_s[e][31:0];
          end
        end
        default: begin
          err2_s = 1'b1;
        end
      endcase
    end else begin
      data2_s = '0;
      sew2_s  = '0;
      err2_s  = 1'b0;
    end
  end

  // Stage-2 output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sew   <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= v1_r;
      out_data  <= data2_s;
      out_sew   <= sew2_s;
      out_err   <= err2_s;
    end
  end

endmodule

// File: tb/tb_mult_product_combine.sv
// Self-checking bench for mult_product_combine: directed scenarios plus randomized
// element operands checked against full-precision products computed in the bench.
module tb_mult_product_combine;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [287:0]  in_prod;
  logic [1:0]    in_sew;
  logic          in_hi;
  logic          out_valid;
  logic [63:0]   out_data;
  logic [1:0]    out_sew;
  logic          out_err;

  int vectors     = 0;
  int miscompares = 0;
  logic [67:0] exp_q [$];

  always #5 clk = ~clk;

  mult_product_combine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .in_sew    (in_sew),
    .in_hi     (in_hi),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sew   (out_sew),
    .out_err   (out_err)
  );

  function automatic logic [287:0] pack(input logic [35:0] p [8]);
    logic [287:0] r;
    for (int k = 0; k < 8; k++) r[36*k +: 36] = p[k];
    return r;
  endfunction

  function automatic logic [287:0] rand_prod();
    logic [287:0] r;
    for (int k = 0; k < 9; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [67:0] observed();
    return {out_valid, out_err, out_sew, out_data};
  endfunction

  // Drive one cycle of inputs, let the edge capture them, then settle before sampling.
  task automatic apply(input logic v, input logic [287:0] p, input logic [1:0] s,
                       input logic h, input logic r);
    rst = r; in_valid = v; in_prod = p; in_sew = s; in_hi = h;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    apply(1'b0, rand_prod(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_reset();
    logic [67:0] got;
    apply(1'b1, rand_prod(), 2'd2, 1'b1, 1'b1);
    apply(1'b1, rand_prod(), 2'd1, 1'b0, 1'b1);
    got = observed();
    vectors++;
    if (got !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", got, 68'd0);
    end
    bubble();
    got = observed();
    vectors++;
    if (got !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", got, 68'd0);
    end
  endtask

  task automatic test_sew8();
    logic [35:0] p [8];
    logic [67:0] got;
    for (int k = 0; k < 8; k++) p[k] = 36'hF_FFFF_FFF1;
    apply(1'b1, pack(p), 2'd0, 1'b0, 1'b0);
    apply(1'b1, pack(p), 2'd0, 1'b1, 1'b0);
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd0, 64'hF1F1_F1F1_F1F1_F1F1}) begin
      miscompares++;
      $display("FAIL sew8_lo: got %h expected %h", got, {1'b1, 1'b0, 2'd0, 64'hF1F1_F1F1_F1F1_F1F1});
    end
    bubble();
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      miscompares++;
      $display("FAIL sew8_hi: got %h expected %h", got, {1'b1, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    end
    bubble();
    got = observed();
    vectors++;
    if (got !== 68'd0) begin
      miscompares++;
      $display("FAIL bubble_zero: got %h expected %h", got, 68'd0);
    end
  endtask

  task automatic test_sew16();
    logic [35:0] p [8];
    logic [67:0] got;
    p[0] = 36'h0_1234_5678;
    for (int k = 1; k < 4; k++) p[k] = 36'h0;
    for (int k = 4; k < 8; k++) p[k] = {4'($urandom()), 32'($urandom())};
    apply(1'b1, pack(p), 2'd1, 1'b0, 1'b0);
    apply(1'b1, pack(p), 2'd1, 1'b1, 1'b0);
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd1, 64'h0000_0000_0000_5678}) begin
      miscompares++;
      $display("FAIL sew16_lo: got %h expected %h", got, {1'b1, 1'b0, 2'd1, 64'h5678});
    end
    bubble();
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd1, 64'h0000_0000_0000_1234}) begin
      miscompares++;
      $display("FAIL sew16_hi: got %h expected %h", got, {1'b1, 1'b0, 2'd1, 64'h1234});
    end
  endtask

  task automatic test_sew32();
    logic [35:0] pa [8];
    logic [35:0] pb [8];
    logic [67:0] got;
    for (int k = 0; k < 8; k++) pa[k] = 36'h0_FFFE_0001;
    pb[0] = 36'h0_0001_FFFE;
    pb[1] = 36'h0;
    pb[2] = 36'hF_FFFF_FFFE;
    pb[3] = 36'h0;
    for (int k = 4; k < 8; k++) pb[k] = 36'h0;
    apply(1'b1, pack(pa), 2'd2, 1'b0, 1'b0);
    apply(1'b1, pack(pa), 2'd2, 1'b1, 1'b0);
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd2, 64'h0000_0001_0000_0001}) begin
      miscompares++;
      $display("FAIL sew32_unsigned_lo: got %h expected %h", got, {1'b1, 1'b0, 2'd2, 64'h0000_0001_0000_0001});
    end
    apply(1'b1, pack(pb), 2'd2, 1'b0, 1'b0);
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd2, 64'hFFFF_FFFE_FFFF_FFFE}) begin
      miscompares++;
      $display("FAIL sew32_unsigned_hi: got %h expected %h", got, {1'b1, 1'b0, 2'd2, 64'hFFFF_FFFE_FFFF_FFFE});
    end
    apply(1'b1, pack(pb), 2'd2, 1'b1, 1'b0);
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd2, 64'h0000_0000_FFFF_FFFE}) begin
      miscompares++;
      $display("FAIL sew32_signed_lo: got %h expected %h", got, {1'b1, 1'b0, 2'd2, 64'h0000_0000_FFFF_FFFE});
    end
    bubble();
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd2, 64'h0000_0000_FFFF_FFFF}) begin
      miscompares++;
      $display("FAIL sew32_signed_hi: got %h expected %h", got, {1'b1, 1'b0, 2'd2, 64'h0000_0000_FFFF_FFFF});
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] p8 [8];
    logic [35:0] p16 [8];
    logic [35:0] p32 [8];
    logic [67:0] got;
    for (int k = 0; k < 8; k++) begin
      p8[k]  = 36'hF_FFFF_FFF1;
      p16[k] = 36'h0;
      p32[k] = 36'h0_FFFE_0001;
    end
    p16[0] = 36'h0_1234_5678;
    apply(1'b1, pack(p8),  2'd0, 1'b0, 1'b0);
    apply(1'b1, pack(p16), 2'd1, 1'b1, 1'b0);
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd0, 64'hF1F1_F1F1_F1F1_F1F1}) begin
      miscompares++;
      $display("FAIL b2b_beat0: got %h expected %h", got, {1'b1, 1'b0, 2'd0, 64'hF1F1_F1F1_F1F1_F1F1});
    end
    apply(1'b1, pack(p32), 2'd2, 1'b0, 1'b0);
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd1, 64'h0000_0000_0000_1234}) begin
      miscompares++;
      $display("FAIL b2b_beat1: got %h expected %h", got, {1'b1, 1'b0, 2'd1, 64'h1234});
    end
    bubble();
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b0, 2'd2, 64'h0000_0001_0000_0001}) begin
      miscompares++;
      $display("FAIL b2b_beat2: got %h expected %h", got, {1'b1, 1'b0, 2'd2, 64'h0000_0001_0000_0001});
    end
    bubble();
    got = observed();
    vectors++;
    if (got !== 68'd0) begin
      miscompares++;
      $display("FAIL b2b_drain: got %h expected %h", got, 68'd0);
    end
  endtask

  task automatic test_reset_inflight();
    logic [67:0] got;
    apply(1'b1, rand_prod(), 2'd0, 1'b0, 1'b0);
    apply(1'b1, rand_prod(), 2'd1, 1'b1, 1'b0);
    apply(1'b1, rand_prod(), 2'd2, 1'b0, 1'b1);
    got = observed();
    vectors++;
    if (got !== 68'd0) begin
      miscompares++;
      $display("FAIL inflight_rst: got %h expected %h", got, 68'd0);
    end
    for (int c = 0; c < 2; c++) begin
      bubble();
      got = observed();
      vectors++;
      if (got !== 68'd0) begin
        miscompares++;
        $display("FAIL inflight_flush%0d: got %h expected %h", c, got, 68'd0);
      end
    end
    apply(1'b1, rand_prod(), 2'd3, 1'($urandom_range(0, 1)), 1'b0);
    bubble();
    got = observed();
    vectors++;
    if (got !== {1'b1, 1'b1, 2'd3, 64'h0}) begin
      miscompares++;
      $display("FAIL sew64_err: got %h expected %h", got, {1'b1, 1'b1, 2'd3, 64'h0});
    end
    bubble();
  endtask

  task automatic test_random(input int n);
    logic        v, h, sg;
    logic [1:0]  s;
    logic [35:0] p [8];
    logic [63:0] d;
    logic [67:0] e, got;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic [31:0] a32, b32;
    longint      pr, al, ah, bl, bh, full;
    exp_q = {};
    exp_q.push_back(68'd0);
    for (int t = 0; t < n; t++) begin
      v  = ($urandom_range(0, 3) != 0);
      s  = 2'($urandom_range(0, 3));
      h  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) p[k] = {4'($urandom()), 32'($urandom())};
      d = 64'h0;
      case (s)
        2'd0: begin
          for (int i = 0; i < 8; i++) begin
            a8 = 8'($urandom()); b8 = 8'($urandom());
            pr = sg ? longint'($signed(a8)) * longint'($signed(b8)) : longint'(a8) * longint'(b8);
            p[i] = pr[35:0];
            d[8*i +: 8] = h ? pr[15:8] : pr[7:0];
          end
        end
        2'd1: begin
          for (int i = 0; i < 4; i++) begin
            a16 = 16'($urandom()); b16 = 16'($urandom());
            pr = sg ? longint'($signed(a16)) * longint'($signed(b16)) : longint'(a16) * longint'(b16);
            p[i] = pr[35:0];
            d[16*i +: 16] = h ? pr[31:16] : pr[15:0];
          end
        end
        2'd2: begin
          for (int w = 0; w < 2; w++) begin
            a32 = $urandom(); b32 = $urandom();
            al = longint'(a32[15:0]);
            bl = longint'(b32[15:0]);
            ah = sg ? longint'($signed(a32[31:16])) : longint'(a32[31:16]);
            bh = sg ? longint'($signed(b32[31:16])) : longint'(b32[31:16]);
            pr = al * bl; p[4*w]     = pr[35:0];
            pr = al * bh; p[4*w + 1] = pr[35:0];
            pr = ah * bl; p[4*w + 2] = pr[35:0];
            pr = ah * bh; p[4*w + 3] = pr[35:0];
            full = sg ? longint'($signed(a32)) * longint'($signed(b32)) : longint'(a32) * longint'(b32);
            d[32*w +: 32] = h ? full[63:32] : full[31:0];
          end
        end
        default: d = 64'h0;
      endcase
      e = v ? {1'b1, (s == 2'd3), s, d} : 68'd0;
      exp_q.push_back(e);
      apply(v, pack(p), s, h, 1'b0);
      e = exp_q.pop_front();
      got = observed();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", t, got, e);
      end
    end
    bubble();
    e = exp_q.pop_front();
    got = observed();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL random_last: got %h expected %h", got, e);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_sew = 2'd0; in_hi = 1'b0;
    test_reset();
    test_sew8();
    test_sew16();
    test_sew32();
    test_back_to_back();
    test_reset_inflight();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
